inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter AW, default 4, instruction-memory word-address width (16-entry program).
REQ-002 Parameter DW, default 32, instruction width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  run enable; fetching starts/continues only while high.
REQ-006 halt  in  1  stop request, honoured at the next instruction boundary.
REQ-007 jmp_valid  in  1  redirect request, single-cycle pulse.
REQ-008 jmp_addr  in  AW  redirect target word address.
REQ-009 imem_rd  out  1  instruction-memory read strobe.
REQ-010 imem_addr  out  AW  instruction-memory word address.
REQ-011 imem_rdata  in  DW  read data, valid exactly 1 cycle after imem_rd.
REQ-012 ir  out  DW  instruction register to decode.
REQ-013 ir_pc  out  AW  address of the instruction held in ir.
REQ-014 ir_valid  out  1  ir holds a fresh instruction.
REQ-015 ir_ready  in  1  decode accepts ir.
REQ-016 pc  out  AW  next address to fetch.
REQ-017 halted  out  1  block is in HALT.

Function
REQ-018 FSM states IDLE, FETCH, WAIT, HOLD, HALT; all outputs registered except imem_rd/imem_addr.
REQ-019 IDLE: en=1 and halt=0 -> FETCH; en=1 and halt=1 -> HALT; else stay.
REQ-020 FETCH: imem_rd=1, imem_addr=pc, for exactly one cycle; -> WAIT. imem_rd=0 in every other state.
REQ-021 WAIT: ir<=imem_rdata, ir_pc<=pc, ir_valid<=1, pc<=pc+1 modulo 2^AW (pc 15 wraps to 0 at AW=4); -> HOLD.
REQ-022 HOLD: ir, ir_pc, ir_valid stable while ir_ready=0.
REQ-023 HOLD with ir_ready=1: ir_valid<=0 next cycle; then halt=1 -> HALT, else en=0 -> IDLE, else -> FETCH.
REQ-024 Minimum spacing 3 cycles per instruction (FETCH, WAIT, HOLD with ir_ready=1).
REQ-025 jmp_valid=1 in FETCH, WAIT or HOLD: pc<=jmp_addr, ir_valid<=0, -> FETCH; in-flight read data and any un-accepted ir discarded.
REQ-026 jmp_valid has priority over ir_ready and halt in the same cycle; halt then takes effect at the next boundary.
REQ-027 jmp_valid ignored in IDLE and HALT.
REQ-028 halt is level-sampled only at boundaries (IDLE exit, HOLD handshake); HALT is sticky until reset; halted=1 only in HALT.
REQ-029 en falling during FETCH/WAIT/HOLD does not abort the current instruction; it stops only at the boundary.

Reset
REQ-030 rst_n=0 asynchronously forces state IDLE, pc=0, ir=0, ir_pc=0, ir_valid=0, halted=0, imem_rd=0, imem_addr=0.
REQ-031 Reset mid-operation discards any in-flight read; first fetch after release is address 0.

Structure
REQ-032 Shared package holds the FSM state enum, AW/DW defaults and the reset-PC constant (0).
REQ-033 One sub-module, fetch_pc_reg (load/increment/hold, wrap at 2^AW); everything else inline.

Verification
REQ-034 Memory words 0..3 = 0x11111111..0x44444444, en=1, ir_ready=1 -> imem_addr 0,1,2,3 every 3 cycles; ir/ir_pc match word/address.
REQ-035 ir_ready held low 5 cycles in HOLD -> ir=0x11111111, ir_pc=0 stable, no imem_rd until accepted.
REQ-036 jmp_valid with jmp_addr=9 in WAIT -> no ir_valid for the discarded word; next imem_addr=9, then ir_pc=9.
REQ-037 jmp_valid and ir_ready in the same HOLD cycle, jmp_addr=2 -> ir flushed, next fetch address 2.
REQ-038 pc=15 fetched with AW=4 -> pc wraps to 0; halt=1 at handshake -> halted=1, no further imem_rd, jmp ignored.
REQ-039 rst_n pulsed low during WAIT -> all outputs 0 immediately; after release and en=1 first imem_addr=0.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch block.
//   - Default address/data widths for the fetch unit.
//   - Program counter value loaded by reset.
//   - Fetch FSM state encoding.
package inst_fetch_pkg;

  localparam int AW_DEFAULT = 4;
  localparam int DW_DEFAULT = 32;
  localparam int RESET_PC   = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch unit.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (pc -> RESET_PC)
//   load      in   load load_addr (takes priority over inc)
//   load_addr in   AW  redirect target
//   inc       in   advance pc by one, wrapping at 2^AW
//   pc        out  AW  current program counter
module fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [AW-1:0] load_addr,
  input  logic          inc,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= AW'(RESET_PC);
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      // Natural AW-bit overflow gives the modulo-2^AW wrap.
      pc <= pc + AW'(1);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Single-issue instruction fetch unit.
// One instruction at a time: FETCH issues the read, WAIT captures the
// returned word into ir, HOLD presents it to decode until accepted.
// Ports:
//   clk, rst_n           clock / asynchronous active-low reset
//   en                   run enable, checked at instruction boundaries
//   halt                 stop request, checked at instruction boundaries
//   jmp_valid, jmp_addr  redirect pulse and target word address
//   imem_rd, imem_addr   instruction memory read strobe / address
//   imem_rdata           read data, valid one cycle after imem_rd
//   ir, ir_pc, ir_valid  instruction register, its address, valid flag
//   ir_ready             decode accepts ir
//   pc                   next address to fetch
//   halted               block is in HALT (sticky until reset)
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          halt,
  input  logic          jmp_valid,
  input  logic [AW-1:0] jmp_addr,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [AW-1:0] pc,
  output logic          halted
);

  state_t state;
  state_t state_nxt;
  logic   pc_load;
  logic   pc_inc;
  logic   ir_load;
  logic   ir_drop;

  fetch_pc_reg #(
    .AW(AW)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pc_load),
    .load_addr(jmp_addr),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A redirect in FETCH/WAIT/HOLD wins over everything else; the word
  // still in flight is simply never captured because we go back to FETCH.
  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    ir_load   = 1'b0;
    ir_drop   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (en) begin
          state_nxt = halt ? S_HALT : S_FETCH;
        end
      end
      S_FETCH: begin
        if (jmp_valid) begin
          pc_load   = 1'b1;
          ir_drop   = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (jmp_valid) begin
          pc_load   = 1'b1;
          ir_drop   = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (jmp_valid) begin
          pc_load   = 1'b1;
          ir_drop   = 1'b1;
          state_nxt = S_FETCH;
        end else if (ir_ready) begin
          ir_drop = 1'b1;
          if (halt) begin
            state_nxt = S_HALT;
          end else if (!en) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Read strobe and address are decoded straight from the state so the
  // memory sees the request in the FETCH cycle itself.
  assign imem_rd   = (state == S_FETCH);
  assign imem_addr = imem_rd ? pc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      halted <= (state_nxt == S_HALT);
      if (ir_load) begin
        ir       <= imem_rdata;
        ir_pc    <= pc;
        ir_valid <= 1'b1;
      end else if (ir_drop) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule
